// File: rtl/ksa4_pipe_adder.sv
// ksa4_pipe_adder: 4-bit Kogge-Stone adder, 4-stage pipeline; optional valid tracking via KSA4_VALID_EN
module ksa4_pipe_adder (
  input  logic GCLK_Pad,
  input  logic RSTN_Pad,
  input  logic a0_Pad,
  input  logic a1_Pad,
  input  logic a2_Pad,
  input  logic a3_Pad,
  input  logic b0_Pad,
  input  logic b1_Pad,
  input  logic b2_Pad,
  input  logic b3_Pad,
  input  logic cin_Pad,
`ifdef KSA4_VALID_EN
  input  logic in_valid_Pad,
  output logic out_valid_Pad,
`endif
  output logic sum0_Pad,
  output logic sum1_Pad,
  output logic sum2_Pad,
  output logic sum3_Pad,
  output logic cout_Pad
);
  logic [3:0] a, b;
  logic [3:0] s1_p_d, s1_p_q, s1_g_d, s1_g_q;
  logic       s1_c_d, s1_c_q;
  logic [3:0] s2_p_d, s2_p_q;
  logic [3:0] s2_g_d, s2_g_q;
  logic [1:0] s2_pp_d, s2_pp_q;
  logic       s2_c_d, s2_c_q;
  logic [3:0] s3_p_d, s3_p_q, s3_g_d, s3_g_q;
  logic       s3_c_d, s3_c_q;
  logic [3:0] sum_d, sum_q;
  logic       cout_d, cout_q;
  logic       upd;
  assign a = {a3_Pad, a2_Pad, a1_Pad, a0_Pad};
  assign b = {b3_Pad, b2_Pad, b1_Pad, b0_Pad};
`ifdef KSA4_VALID_EN
  logic [3:0] v_d, v_q;
  assign v_d = {v_q[2:0], in_valid_Pad};
  assign upd = v_q[2];
  assign out_valid_Pad = v_q[3];
`else
  assign upd = 1'b1;
`endif
  // Pipeline next-state: generate/propagate, two prefix levels, then sum formation
  always_comb begin
    s1_p_d  = a ^ b;
    s1_g_d  = {a[3:1] & b[3:1], (a[0] & b[0]) | ((a[0] ^ b[0]) & cin_Pad)};
    s1_c_d  = cin_Pad;
    s2_g_d  = {s1_g_q[3] | (s1_p_q[3] & s1_g_q[2]),
               s1_g_q[2] | (s1_p_q[2] & s1_g_q[1]),
               s1_g_q[1] | (s1_p_q[1] & s1_g_q[0]),
               s1_g_q[0]};
    s2_pp_d = {s1_p_q[3] & s1_p_q[2], s1_p_q[2] & s1_p_q[1]};
    s2_p_d  = s1_p_q;
    s2_c_d  = s1_c_q;
    s3_g_d  = {s2_g_q[3] | (s2_pp_q[1] & s2_g_q[1]),
               s2_g_q[2] | (s2_pp_q[0] & s2_g_q[0]),
               s2_g_q[1],
               s2_g_q[0]};
    s3_p_d  = s2_p_q;
    s3_c_d  = s2_c_q;
    sum_d   = upd ? s3_p_q ^ {s3_g_q[2:0], s3_c_q} : sum_q;
    cout_d  = upd ? s3_g_q[3] : cout_q;
  end
  // Pipeline registers with synchronous active-low clear
  always_ff @(posedge GCLK_Pad) begin
    if (!RSTN_Pad) begin
      s1_p_q <= '0; s1_g_q <= '0; s1_c_q <= 1'b0;
      s2_p_q <= '0; s2_g_q <= '0; s2_pp_q <= '0; s2_c_q <= 1'b0;
      s3_p_q <= '0; s3_g_q <= '0; s3_c_q <= 1'b0;
      sum_q  <= '0; cout_q <= 1'b0;
    end else begin
      s1_p_q <= s1_p_d; s1_g_q <= s1_g_d; s1_c_q <= s1_c_d;
      s2_p_q <= s2_p_d; s2_g_q <= s2_g_d; s2_pp_q <= s2_pp_d; s2_c_q <= s2_c_d;
      s3_p_q <= s3_p_d; s3_g_q <= s3_g_d; s3_c_q <= s3_c_d;
      sum_q  <= sum_d; cout_q <= cout_d;
    end
  end
`ifdef KSA4_VALID_EN
  // Valid shift register aligned with the data stages
  always_ff @(posedge GCLK_Pad) begin
    if (!RSTN_Pad) v_q <= '0;
    else v_q <= v_d;
  end
`endif
  assign {sum3_Pad, sum2_Pad, sum1_Pad, sum0_Pad} = sum_q;
  assign cout_Pad = cout_q;
endmodule

// File: tb/tb_ksa4_pipe_adder.sv
// tb_ksa4_pipe_adder: table-driven and randomized checks against a queue-based sum model
module tb_ksa4_pipe_adder;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic cin = 1'b0;
  logic s0, s1, s2, s3, co;
  logic [4:0] got;
  logic [4:0] pipe [4];
  int pass_cnt = 0, total = 0;

  typedef struct { logic [3:0] a; logic [3:0] b; logic c; logic [4:0] exp; } vec_t;
  vec_t tab [9];

  ksa4_pipe_adder dut (
    .GCLK_Pad(clk), .RSTN_Pad(rstn),
    .a0_Pad(a[0]), .a1_Pad(a[1]), .a2_Pad(a[2]), .a3_Pad(a[3]),
    .b0_Pad(b[0]), .b1_Pad(b[1]), .b2_Pad(b[2]), .b3_Pad(b[3]),
    .cin_Pad(cin),
    .sum0_Pad(s0), .sum1_Pad(s1), .sum2_Pad(s2), .sum3_Pad(s3), .cout_Pad(co)
  );

  always #5 clk = ~clk;
  assign got = {co, s3, s2, s1, s0};

  task automatic check(input string nm, input logic [4:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got {cout,sum}=%b expected %b at %0t", nm, got, exp, $time);
  endtask

  // One clock: drive at negedge, advance model on the edge, optionally compare at next negedge
  task automatic cyc(input logic [3:0] ai, input logic [3:0] bi, input logic ci, input logic ri,
                     input bit chk, input string nm);
    a = ai; b = bi; cin = ci; rstn = ri;
    @(posedge clk);
    if (!ri) for (int i = 0; i < 4; i++) pipe[i] = '0;
    else begin
      for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = 5'(ai) + 5'(bi) + 5'(ci);
    end
    @(negedge clk);
    if (chk) check(nm, pipe[3]);
  endtask

  initial begin
    tab[0] = '{4'd1,  4'd9,  1'b1, 5'd11};
    tab[1] = '{4'd15, 4'd4,  1'b1, 5'd20};
    tab[2] = '{4'd8,  4'd14, 1'b1, 5'd23};
    tab[3] = '{4'd15, 4'd0,  1'b1, 5'd16};
    tab[4] = '{4'd15, 4'd15, 1'b1, 5'd31};
    tab[5] = '{4'd1,  4'd4,  1'b1, 5'd6};
    tab[6] = '{4'd1,  4'd0,  1'b0, 5'd1};
    tab[7] = '{4'd0,  4'd1,  1'b0, 5'd1};
    tab[8] = '{4'd5,  4'd12, 1'b0, 5'd17};
    for (int i = 0; i < 4; i++) pipe[i] = '0;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      cyc(4'($urandom), 4'($urandom), 1'($urandom), 1'b0, 1'b1, "reset");
    for (int i = 0; i < 5; i++) cyc(4'd0, 4'd0, 1'b0, 1'b1, 1'b1, "zero_after_reset");
    for (int i = 0; i < 12; i++) begin
      if (i < 9) cyc(tab[i].a, tab[i].b, tab[i].c, 1'b1, 1'b0, "");
      else cyc(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, "");
      if (i >= 3) check($sformatf("table[%0d]", i - 3), tab[i-3].exp);
    end
    for (int i = 0; i < 3; i++) cyc(4'd7, 4'd9 - 4'(i), 1'b1, 1'b1, 1'b0, "");
    cyc(4'd0, 4'd0, 1'b0, 1'b0, 1'b1, "midflight_reset");
    for (int i = 0; i < 4; i++) begin
      cyc(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, "");
      check("midflight_flushed", 5'd0);
    end
    for (int i = 0; i < 300; i++)
      cyc(4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 39) != 0), 1'b1, "random");
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
